seg7_hex_writer: RTL

- Avalon-MM master that drives the Terasic SEG7 register-file slave from the initiator side.
- Takes a packed hex value plus a decimal-point mask from user logic and converts each nibble to a 7-segment code using the standard map.
- Issues one 8-bit write per digit, digit index used as the slave address.
- Lets hardware, not a CPU, update the seg7 array, and skips digits whose code is unchanged.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_hex_encode.sv | 22 ++
 rtl/seg7_hex_writer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the seg7 display blocks:
//     SEG7_HEX_MAP  - nibble to 7-segment code (bit6..0 = g..a, 1 = lit)
//     SEG7_DP_BIT   - position of the decimal-point bit in a written code
//     seg7_state_e  - sequencing states of the seg7_hex_writer master
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int SEG7_DP_BIT  = 7;
   localparam int SEG7_SEG_MSB = 6;

   // Index 0 is the leftmost element, so SEG7_HEX_MAP[n] is the code for n.
   localparam logic [0:15][7:0] SEG7_HEX_MAP = {
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FIN   = 2'd3
   } seg7_state_e;

endpackage

// File: rtl/seg7_hex_encode.sv
// -----------------------------------------------------------------------------
// seg7_hex_encode
//   Combinational nibble + decimal point to 8-bit segment code.
//   Ports:
//     i_nibble : hex digit 0..F
//     i_dp     : decimal point on
//     o_code   : {dp, g..a}, 1 = segment lit
// -----------------------------------------------------------------------------
module seg7_hex_encode
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_dp,
   output logic [7:0] o_code
);

   always_comb begin
      o_code              = SEG7_HEX_MAP[i_nibble];
      o_code[SEG7_DP_BIT] = i_dp;
   end

endmodule

// File: rtl/seg7_hex_writer.sv
// -----------------------------------------------------------------------------
// seg7_hex_writer
//   Avalon-MM master that refreshes a SEG7 register-file slave from a packed
//   hex value. One 8-bit write per digit, digit index on the address bus.
//   Digits whose code matches the last code written are skipped when
//   CHANGED_ONLY is set.
//
//   Ports:
//     avm_m1_clk / avm_m1_reset_n : clock, async active-low reset
//     hex_value  : nibble i (bits 4i+3:4i) shown on digit i
//     dp_mask    : bit i lights the decimal point of digit i
//     update     : one-cycle refresh request
//     busy       : refresh sequence in progress
//     done       : one-cycle pulse at the end of a sequence
//     avm_m1_address / avm_m1_write / avm_m1_writedata : Avalon write port
//     avm_m1_waitrequest : slave stall
//     dbg_state  : current sequencing state
//
//   Handshake: address, writedata and write are held stable while
//   waitrequest=1; a transfer completes on the rising edge where write=1 and
//   waitrequest=0, and write is low for at least one SCAN cycle afterwards.
// -----------------------------------------------------------------------------
module seg7_hex_writer
   import seg7_pkg::*;
#(
   parameter int SEG7_NUM     = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int CHANGED_ONLY = 1
)(
   input  logic                    avm_m1_clk,
   input  logic                    avm_m1_reset_n,
   input  logic [SEG7_NUM*4-1:0]   hex_value,
   input  logic [SEG7_NUM-1:0]     dp_mask,
   input  logic                    update,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_WIDTH-1:0]   avm_m1_address,
   output logic                    avm_m1_write,
   output logic [7:0]              avm_m1_writedata,
   input  logic                    avm_m1_waitrequest,
   output seg7_state_e             dbg_state
);

   // idx carries one extra bit so the terminal count SEG7_NUM is representable.
   localparam logic [ADDR_WIDTH:0] C_LAST_IDX     = (ADDR_WIDTH+1)'(SEG7_NUM);
   localparam logic [ADDR_WIDTH:0] C_IDX_ONE      = (ADDR_WIDTH+1)'(1);
   localparam bit                  C_CHANGED_ONLY = (CHANGED_ONLY != 0);

   seg7_state_e             r_state;
   seg7_state_e             w_next;
   logic [ADDR_WIDTH:0]     r_idx;
   logic [SEG7_NUM*4-1:0]   r_snap_hex;
   logic [SEG7_NUM-1:0]     r_snap_dp;
   logic [7:0]              r_shadow [SEG7_NUM];
   logic [SEG7_NUM-1:0]     r_shadow_valid;
   logic                    r_pending;
   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_address;
   logic [7:0]              r_writedata;

   logic [ADDR_WIDTH-1:0]   w_digit;
   logic [3:0]              w_nibble;
   logic                    w_dp;
   logic [7:0]              w_code;
   logic                    w_at_end;
   logic                    w_skip;
   logic                    w_restart;

   assign w_digit  = r_idx[ADDR_WIDTH-1:0];
   assign w_nibble = r_snap_hex[{w_digit, 2'b00} +: 4];
   assign w_dp     = r_snap_dp[w_digit];
   assign w_at_end = (r_idx == C_LAST_IDX);

   seg7_hex_encode u_encode (
      .i_nibble (w_nibble),
      .i_dp     (w_dp),
      .o_code   (w_code)
   );

   // A digit is skipped only when the slave is known to hold this exact code.
   assign w_skip = C_CHANGED_ONLY && r_shadow_valid[w_digit] &&
                   (r_shadow[w_digit] == w_code);

   // An update arriving in FIN counts the same as one already pending.
   assign w_restart = r_pending | update;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (update) w_next = ST_SCAN;
         ST_SCAN: begin
            if (w_at_end)     w_next = ST_FIN;
            else if (!w_skip) w_next = ST_WRITE;
         end
         ST_WRITE: if (!avm_m1_waitrequest) w_next = ST_SCAN;
         ST_FIN:   w_next = w_restart ? ST_SCAN : ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge avm_m1_clk or negedge avm_m1_reset_n) begin
      if (!avm_m1_reset_n) begin
         r_state        <= ST_IDLE;
         r_idx          <= '0;
         r_snap_hex     <= '0;
         r_snap_dp      <= '0;
         r_shadow_valid <= '0;
         r_pending      <= 1'b0;
         r_write        <= 1'b0;
         r_address      <= '0;
         r_writedata    <= '0;
         for (int i = 0; i < SEG7_NUM; i++) r_shadow[i] <= '0;
      end else begin
         r_state <= w_next;

         // 1-deep sticky request; consumed at FIN where the restart happens.
         if (r_state == ST_FIN)
            r_pending <= 1'b0;
         else if (update && (r_state != ST_IDLE))
            r_pending <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (update) begin
                  r_snap_hex <= hex_value;
                  r_snap_dp  <= dp_mask;
                  r_idx      <= '0;
               end
            end
            ST_SCAN: begin
               if (!w_at_end) begin
                  if (w_skip) begin
                     r_idx <= r_idx + C_IDX_ONE;
                  end else begin
                     r_write     <= 1'b1;
                     r_address   <= w_digit;
                     r_writedata <= w_code;
                  end
               end
            end
            ST_WRITE: begin
               if (!avm_m1_waitrequest) begin
                  r_write                 <= 1'b0;
                  r_shadow[w_digit]       <= r_writedata;
                  r_shadow_valid[w_digit] <= 1'b1;
                  r_idx                   <= r_idx + C_IDX_ONE;
               end
            end
            ST_FIN: begin
               if (w_restart) begin
                  r_snap_hex <= hex_value;
                  r_snap_dp  <= dp_mask;
                  r_idx      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy             = (r_state != ST_IDLE);
   assign done             = (r_state == ST_FIN);
   assign avm_m1_write     = r_write;
   assign avm_m1_address   = r_address;
   assign avm_m1_writedata = r_writedata;
   assign dbg_state        = r_state;

endmodule
